// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, h/v counters, syncs and strobes.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_generator #(
   parameter int CLK_DIV         = 2,
   parameter int H_DISPLAY       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_DISPLAY       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [9:0]  h_count,
   output logic [9:0]  v_count,
   output logic        display_enable,
   output logic        hsync,
   output logic        vsync,
   output logic        pix_tick,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed 10-bit counters");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_generator: CLK_DIV must be >= 1");
   end

   localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
   localparam logic [9:0] HMAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] VMAX = 10'(V_TOTAL - 1);
   localparam logic [10:0] HD  = 11'(H_DISPLAY);
   localparam logic [10:0] HS0 = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS1 = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VD  = 11'(V_DISPLAY);
   localparam logic [10:0] VS0 = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS1 = 11'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic S_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic S_OFF = ~S_ON;

   typedef enum logic [1:0] {
      ACTIVE,
      FRONT,
      SYNC,
      BACK
   } region_e;

   function automatic region_e region(
      input logic [9:0]  c,
      input logic [10:0] d,
      input logic [10:0] s0,
      input logic [10:0] s1
   );
      if ({1'b0, c} < d)       return ACTIVE;
      else if ({1'b0, c} < s0) return FRONT;
      else if ({1'b0, c} < s1) return SYNC;
      else                     return BACK;
   endfunction

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    h_q, h_d, v_q, v_d;
   logic          de_q, hs_q, vs_q, tick_q, line_q, frame_q;
   logic          tick, line_d, frame_d;
   region_e       h_reg, v_reg;

   always_comb begin
      tick    = (div_q == DMAX);
      div_d   = tick ? '0 : div_q + DW'(1);
      h_d     = h_q;
      v_d     = v_q;
      line_d  = 1'b0;
      frame_d = 1'b0;
      if (tick) begin
         if (h_q == HMAX) begin
            h_d    = '0;
            v_d    = (v_q == VMAX) ? '0 : v_q + 10'd1;
            line_d = 1'b1;
            frame_d = (v_q == VMAX);
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      // Regions decode the next counts so syncs line up with the counters.
      h_reg = region(h_d, HD, HS0, HS1);
      v_reg = region(v_d, VD, VS0, VS1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         h_q     <= HMAX;
         v_q     <= VMAX;
         de_q    <= 1'b0;
         hs_q    <= S_OFF;
         vs_q    <= S_OFF;
         tick_q  <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         de_q    <= (h_reg == ACTIVE) && (v_reg == ACTIVE);
         hs_q    <= (h_reg == SYNC) ? S_ON : S_OFF;
         vs_q    <= (v_reg == SYNC) ? S_ON : S_OFF;
         tick_q  <= tick;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] fcnt_q;

   always_ff @(posedge clk) begin
      if (rst)          fcnt_q <= '0;
      else if (frame_d) fcnt_q <= fcnt_q + 16'd1;
   end

   assign frame_count = fcnt_q;
`else
   assign frame_count = '0;
`endif

   assign h_count        = h_q;
   assign v_count        = v_q;
   assign display_enable = de_q;
   assign hsync          = hs_q;
   assign vsync          = vs_q;
   assign pix_tick       = tick_q;
   assign line_start     = line_q;
   assign frame_start    = frame_q;

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Raster timing source for the VGA pipeline. Divides the system clock down to a pixel rate and produces `h_count`, `v_count`, `display_enable`, `hsync` and `vsync`. These outputs drive the pixel address generator directly and, through it, the frame-buffer read path. Also provides one-cycle `pix_tick`, `line_start` and `frame_start` strobes so downstream registered stages can qualify their updates.

## Interface
Parameters (defaults give 640x480@60 with a 50 MHz `clk`; values match `vga_pkg`):
- `CLK_DIV`, 2: system clocks per pixel; legal range ≥1.
- `H_DISPLAY`, 640: active pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: active lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `SYNC_ACTIVE_LOW`, 1: 1 means sync pulses drive 0; 0 means sync pulses drive 1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `h_count`  out  10  current pixel column, 0..H_TOTAL-1.
- `v_count`  out  10  current line, 0..V_TOTAL-1.
- `display_enable`  out  1  high when h_count < H_DISPLAY and v_count < V_DISPLAY.
- `hsync`  out  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW.
- `vsync`  out  1  vertical sync, polarity set by SYNC_ACTIVE_LOW.
- `pix_tick`  out  1  one-clk strobe marking the clock edge on which counters advanced.
- `line_start`  out  1  one-clk strobe, high when h_count has just wrapped to 0.
- `frame_start`  out  1  one-clk strobe, high when (h_count, v_count) has just become (0,0).
- `frame_count`  out  16  number of completed frames; see Configuration.

## Operation
- Derived totals: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800); V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (525).
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. An internal tick fires on the clock where `div_cnt` == CLK_DIV-1. With CLK_DIV = 1 the tick fires every cycle.
- Horizontal counter, on each tick:
  - h_count = H_TOTAL-1 → 0.
  - otherwise h_count + 1.
- Vertical counter:
  - advances only on a tick where h_count wraps.
  - v_count = V_TOTAL-1 → 0; otherwise v_count + 1.
- Horizontal region state machine, decoded from h_count: ACTIVE [0, H_DISPLAY-1] → FRONT → SYNC [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751) → BACK → ACTIVE.
- Vertical regions follow the same order on v_count. Vertical SYNC covers lines 490..491.
- Sync assertion: hsync is asserted while the horizontal region is SYNC; vsync is asserted while the vertical region is SYNC. Asserted level is 0 when SYNC_ACTIVE_LOW = 1, else 1.
- Strobe qualification: `line_start` and `frame_start` are only ever high in a cycle where `pix_tick` is high.
- Counter width: 10-bit counters. H_TOTAL and V_TOTAL must be ≤ 1024; this is checked at elaboration.

## Timing
- Register alignment: every output is registered. hsync, vsync and display_enable are computed from the next counter values, so they align with h_count/v_count in the same cycle with zero skew.
- Reset values (hold while `rst` = 1):
  - div_cnt = 0.
  - h_count = H_TOTAL-1 (799), v_count = V_TOTAL-1 (524).
  - display_enable = 0.
  - hsync and vsync at their inactive level.
  - pix_tick, line_start and frame_start = 0.
  - frame_count = 0.
- After reset release: the first tick occurs on the CLK_DIV-th rising edge. On that edge the counters become (0,0), display_enable = 1, and pix_tick, line_start and frame_start are all high.
- Reset mid-frame: `rst` overrides any state on the next edge and restores the reset values above. No partial line is emitted.
- Line period: H_TOTAL × CLK_DIV clocks. Frame period: H_TOTAL × V_TOTAL × CLK_DIV clocks (840000 clocks at the defaults).
- Pixel address generator latency: consumers sample h_count/v_count/display_enable on the `pix_tick` cycle. The address generator is combinational, so the address is valid in that same cycle.

## Configuration
- Macro: `VGA_FRAME_COUNT_EN`.
- With the macro defined:
  - frame_count increments on every frame_start strobe.
  - Wraps 65535 → 0.
  - The frame_start immediately after reset increments it to 1.
- Without the macro:
  - The counter register is not synthesised.
  - frame_count is tied to 0; the port remains so the interface is unchanged.

## Test plan
- Reset and first frame:
  - Hold rst 5 cycles, then release with CLK_DIV = 2.
  - During reset: h = 799, v = 524, display_enable = 0, hsync = vsync = 1.
  - On the 2nd edge after release: h = 0, v = 0, display_enable = 1, frame_start = line_start = pix_tick = 1, each for exactly one clk.
- Horizontal timing:
  - hsync is low for exactly 96 ticks, h_count 656..751.
  - display_enable falls on h = 640.
  - line_start fires every 1600 clocks.
- Vertical timing:
  - vsync is low for lines 490..491 only, 3200 clocks.
  - display_enable stays 0 for v ≥ 480.
  - frame_start period is 840000 clocks.
- Mid-frame reset:
  - Assert rst at h = 300, v = 200 for 1 cycle.
  - Next edge shows h = 799, v = 524; the new frame starts cleanly.
- CLK_DIV = 1 with SYNC_ACTIVE_LOW = 0:
  - pix_tick is constantly high.
  - hsync is high for h 656..751.
  - Frame period is 420000 clocks.
- With `VGA_FRAME_COUNT_EN`:
  - Force frame_count to 65535; the next frame_start gives 0.
  - Without the macro, frame_count stays 0 across 3 frames.
